// File: rtl/packet_dispatcher_pkg.sv
// rtl/packet_dispatcher_pkg.sv - shared packet types and field layout for the SPI-to-framebuffer path
package packet_dispatcher_pkg;

    // Packet header carried alongside each FIFO word.
    typedef enum logic [1:0] {
        PKT_NOP       = 2'b00,
        PKT_PIXEL     = 2'b01,
        PKT_CLEAR     = 2'b10,
        PKT_FRAME_END = 2'b11
    } pkt_type_t;

    // 32-bit packet word layout, MSB first.
    typedef struct packed {
        logic [7:0] v;      // row
        logic [7:0] h;      // column
        logic [3:0] g;      // green nibble
        logic [3:0] b;      // blue nibble
        logic [3:0] rsvd;   // unused
        logic [3:0] r;      // red nibble
    } Packet_t;

    localparam int COLOR_W = 12;
    localparam int ADDR_W  = 16;

    // RGB444 color as it is written to the framebuffer.
    function automatic logic [COLOR_W-1:0] pkt_color(input Packet_t p);
        return {p.r, p.g, p.b};
    endfunction

endpackage

// File: rtl/packet_dispatcher_clear_sweeper.sv
// rtl/packet_dispatcher_clear_sweeper.sv - h/v raster counter used to sweep the framebuffer on CLEAR
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   start        reload h = 0, v = 0
//   en           advance one pixel this cycle
//   h, v         current raster position
//   wrap         h is at its last column this cycle (row ends)
//   done         last pixel of the frame is being visited this cycle
module clear_sweeper #(
    parameter int H_PIX = 256,
    parameter int V_PIX = 192
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       en,
    output logic [7:0] h,
    output logic [7:0] v,
    output logic       wrap,
    output logic       done
);

    localparam logic [7:0] H_LAST = 8'(H_PIX - 1);
    localparam logic [7:0] V_LAST = 8'(V_PIX - 1);

    assign wrap = en && (h == H_LAST);
    assign done = wrap && (v == V_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h <= 8'd0;
            v <= 8'd0;
        end else if (start) begin
            h <= 8'd0;
            v <= 8'd0;
        end else if (en) begin
            if (wrap) begin
                h <= 8'd0;
                // Returning to 0,0 after the last pixel leaves the counter ready for the next sweep.
                v <= done ? 8'd0 : v + 8'd1;
            end else begin
                h <= h + 8'd1;
            end
        end
    end

endmodule

// File: rtl/packet_dispatcher.sv
// rtl/packet_dispatcher.sv - decodes SPI FIFO packets into framebuffer pixel writes, clears and frame pulses
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   fifo_dout         packet word, valid the cycle after fifo_re
//   fifo_packet_type  packet header, valid with fifo_dout
//   fifo_empty        FIFO has no readable word
//   fifo_re           pop one FIFO word
//   fb_we/addr/data   framebuffer write port, addr = {h, v}, data RGB444
//   frame_done        one-cycle pulse on FRAME_END
//   busy              FSM not idle
//   drop_count        saturating count of out-of-range pixel packets
module packet_dispatcher
    import packet_dispatcher_pkg::*;
#(
    parameter int H_PIX = 256,
    parameter int V_PIX = 192
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] fifo_dout,
    input  logic [1:0]  fifo_packet_type,
    input  logic        fifo_empty,
    output logic        fifo_re,
    output logic        fb_we,
    output logic [15:0] fb_addr,
    output logic [11:0] fb_data,
    output logic        frame_done,
    output logic        busy,
    output logic [7:0]  drop_count
);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DECODE,
        CLEAR
    } state_t;

    state_t       state, state_nxt;
    Packet_t      pkt;
    pkt_type_t    ptype;
    logic         in_range;
    logic         drop_inc;
    logic         sweep_start;
    logic         sweep_en;
    logic [7:0]   sweep_h, sweep_v;
    logic         sweep_wrap, sweep_done;
    logic [COLOR_W-1:0] clr_color;
    logic         unused_bits;

    assign pkt         = Packet_t'(fifo_dout);
    assign ptype       = pkt_type_t'(fifo_packet_type);
    assign in_range    = ({24'd0, pkt.h} < 32'(H_PIX)) && ({24'd0, pkt.v} < 32'(V_PIX));
    assign sweep_start = (state == DECODE) && (ptype == PKT_CLEAR);
    assign sweep_en    = (state == CLEAR);
    assign busy        = (state != IDLE);
    assign unused_bits = ^{pkt.rsvd, sweep_wrap};

    clear_sweeper #(
        .H_PIX (H_PIX),
        .V_PIX (V_PIX)
    ) u_sweeper (
        .clk   (clk),
        .rst_n (rst_n),
        .start (sweep_start),
        .en    (sweep_en),
        .h     (sweep_h),
        .v     (sweep_v),
        .wrap  (sweep_wrap),
        .done  (sweep_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            drop_count <= 8'd0;
            clr_color  <= '0;
        end else begin
            state <= state_nxt;
            if (drop_inc && (drop_count != 8'hFF)) begin
                drop_count <= drop_count + 8'd1;
            end
            if (sweep_start) begin
                clr_color <= pkt_color(pkt);
            end
        end
    end

    always_comb begin
        state_nxt  = state;
        fifo_re    = 1'b0;
        fb_we      = 1'b0;
        fb_addr    = '0;
        fb_data    = '0;
        frame_done = 1'b0;
        drop_inc   = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    // IDLE is also the reset state; gating with rst_n keeps the pop low while reset is held.
                    fifo_re   = rst_n;
                    state_nxt = FETCH;
                end
            end
            FETCH: begin
                state_nxt = DECODE;
            end
            DECODE: begin
                state_nxt = IDLE;
                case (ptype)
                    PKT_PIXEL: begin
                        if (in_range) begin
                            fb_we   = 1'b1;
                            fb_addr = {pkt.h, pkt.v};
                            fb_data = pkt_color(pkt);
                        end else begin
                            drop_inc = 1'b1;
                        end
                    end
                    PKT_CLEAR:     state_nxt  = CLEAR;
                    PKT_FRAME_END: frame_done = 1'b1;
                    default:       ;
                endcase
            end
            CLEAR: begin
                fb_we   = 1'b1;
                fb_addr = {sweep_h, sweep_v};
                fb_data = clr_color;
                if (sweep_done) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule
